// File: rtl/flash_read_ctrl_if.sv
// Signal bundle between the flash read controller, the flash pins and the
// read-back/verify fabric. The controller takes the master side.
interface flash_read_ctrl_if;
  // fabric request side
  logic        key;
  logic [31:0] addr;
  logic [7:0]  rd_num;
  // fabric response side
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        rd_done;
  // flash pins
  logic        cs_n;
  logic        spi_clk;
  logic        io0;
  logic        io1;

  modport master (
    input  key, addr, rd_num, io1,
    output rd_data, rd_valid, busy, rd_done, cs_n, spi_clk, io0
  );

  modport slave (
    output key, addr, rd_num, io1,
    input  rd_data, rd_valid, busy, rd_done, cs_n, spi_clk, io0
  );
endinterface

// File: rtl/flash_read_ctrl.sv
// SPI flash READ (0x03) controller, single lane, mode 0.
// A key rising edge while idle latches the 24-bit address and byte count,
// shifts out opcode + address, then streams rd_num+1 bytes back to the fabric.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | cs_n high, waiting for a key rising edge
// SETUP   | cs_n low, spi_clk low, opcode MSB on io0 for CLK_DIV cycles
// CMD     | 8 opcode bits, MSB first
// ADDR    | 24 address bits, addr[23] first
// DATA    | io0 low, MISO shifted into rd_data, one byte per 8 SCK rises
// HOLD    | spi_clk low for CLK_DIV cycles before releasing cs_n
// GAP     | cs_n high for CS_GAP cycles, key ignored
module flash_read_ctrl #(
  parameter int         CLK_DIV = 2,
  parameter logic [7:0] RD_CMD  = 8'h03,
  parameter int         CS_GAP  = 8
) (
  input logic               system_clk,
  input logic               system_reset_n,
  flash_read_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_ADDR  = 3'd3,
    ST_DATA  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } state_e;

  // One down-counter serves both the SCK half-period and the cs_n gap.
  localparam int TMR_MAX = (CS_GAP > CLK_DIV) ? CS_GAP : CLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DIV_LOAD = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(CS_GAP - 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              sck_q, sck_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [8:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        rd_num_q, rd_num_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              key_q;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              rd_done_q, rd_done_d;

  logic              tick;
  logic              shifting;
  logic              sck_rise;
  logic              sck_fall;
  logic              last_bit;
  logic              last_byte;
  logic              accept;
  logic [7:0]        addr_unused;

  // Only the low 24 address bits go to the flash.
  assign addr_unused = bus.addr[31:24];

  assign tick      = (tmr_q == '0);
  assign shifting  = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign sck_rise  = shifting && tick && !sck_q;
  assign sck_fall  = shifting && tick && sck_q;
  assign last_bit  = (bit_cnt_q == 5'd0);
  assign last_byte = (byte_cnt_q == {1'b0, rd_num_q});
  // Edge detect so a key held high starts exactly one transaction.
  assign accept    = (state_q == ST_IDLE) && bus.key && !key_q;

  // State register.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // Next-state logic; shifting states advance on the SCK falling tick of their last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_CMD;
      ST_CMD:   if (sck_fall && last_bit) state_d = ST_ADDR;
      ST_ADDR:  if (sck_fall && last_bit) state_d = ST_DATA;
      ST_DATA:  if (sck_fall && last_bit && last_byte) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_GAP;
      ST_GAP:   if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: cs_n/busy/rd_done are registered from the upcoming state.
  always_comb begin
    cs_n_d    = (state_d == ST_IDLE) || (state_d == ST_GAP);
    busy_d    = !cs_n_d;
    rd_done_d = (state_q == ST_HOLD) && (state_d == ST_GAP);
  end

  // Registered FSM outputs.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      rd_done_q <= rd_done_d;
    end
  end

  // Datapath next values: timer, SCK phase, bit/byte counters, shifters.
  always_comb begin
    tmr_d      = tmr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    rd_num_d   = rd_num_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (state_d == ST_GAP && state_q != ST_GAP) tmr_d = GAP_LOAD;
    else if (state_d == ST_IDLE)                tmr_d = '0;
    else if (state_q == ST_IDLE || tick)        tmr_d = DIV_LOAD;
    else                                        tmr_d = tmr_q - 1'b1;

    // SCK toggles only inside the shifting states, so it never moves with cs_n high.
    sck_d = shifting ? (tick ? ~sck_q : sck_q) : 1'b0;

    if (accept) begin
      bit_cnt_d  = 5'd7;
      byte_cnt_d = 9'd0;
      rd_num_d   = bus.rd_num;
      shift_d    = {RD_CMD, bus.addr[23:0]};
    end else if (sck_fall) begin
      if (last_bit) bit_cnt_d = (state_q == ST_CMD) ? 5'd23 : 5'd7;
      else          bit_cnt_d = bit_cnt_q - 1'b1;
      // Shifting zeros in leaves io0 low for the whole DATA phase.
      if (state_q == ST_CMD || state_q == ST_ADDR) shift_d = {shift_q[30:0], 1'b0};
      if (state_q == ST_DATA && last_bit) byte_cnt_d = byte_cnt_q + 1'b1;
    end

    if (sck_rise && state_q == ST_DATA) begin
      rx_d = {rx_q[5:0], bus.io1};
      if (last_bit) begin
        rd_data_d  = {rx_q, bus.io1};
        rd_valid_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      tmr_q      <= '0;
      sck_q      <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      rx_q       <= '0;
      rd_num_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      key_q      <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      sck_q      <= sck_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      rd_num_q   <= rd_num_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      key_q      <= bus.key;
    end
  end

  assign bus.cs_n     = cs_n_q;
  assign bus.spi_clk  = sck_q;
  assign bus.io0      = shift_q[31];
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.rd_done  = rd_done_q;

endmodule
